// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: multi-lane AES S-box / inverse S-box with a valid/ready pipeline.
// Substitution is done ahead of stage 1; the remaining stages only delay the beat.
//
// Parameters:
//   LANES  - byte lanes per beat (1..16)
//   STAGES - pipeline register stages (1..4)
//   CNT_W  - width of the completed-beat counter
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   flush                - drop all in-flight beats at the next edge
//   in_valid/in_ready    - input handshake
//   in_inv, in_data      - beat mode (1 = inverse) and bytes, lane i = [8i+7:8i]
//   out_valid/out_ready  - output handshake
//   out_data, out_inv    - substituted bytes and the mode bit carried along
//   beat_cnt             - wrapping count of output handshakes
//   busy                 - any stage holds a beat
module aes_sbox_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 busy
);

    localparam int DW = 8 * LANES;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h01;
        p   = a;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    // Forward and inverse share one field inverter:
    //   forward = affine(inv(x)), inverse = inv(inv_affine(x)).
    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        logic [7:0] aff;
        pre = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
        g   = gf_inv(pre);
        aff = g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]}
                ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
        return inv ? g : aff;
    endfunction

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] inv_q;
    logic [DW-1:0]     dat [STAGES];
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] mv;
    logic              down;
    logic [DW-1:0]     sub;

    always_comb begin
        sub = '0;
        for (int l = 0; l < LANES; l++) begin
            sub[8*l +: 8] = sbox(in_data[8*l +: 8], in_inv);
        end
    end

    // Ready ripples back from the output: a stage may load when it is
    // empty or its own beat leaves in the same cycle.
    always_comb begin
        ld   = '0;
        mv   = '0;
        down = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            mv[i] = vld[i] & down;
            ld[i] = ~vld[i] | mv[i];
            down  = ld[i];
        end
    end

    assign in_ready  = rst_n & ~flush & ld[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign out_inv   = inv_q[STAGES-1];
    assign busy      = |vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld      <= '0;
            inv_q    <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
            end
        end else begin
            if (out_valid && out_ready && !flush) begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end
            if (flush) begin
                vld <= '0;
            end else begin
                if (ld[0]) begin
                    vld[0] <= in_valid;
                    if (in_valid) begin
                        dat[0]   <= sub;
                        inv_q[0] <= in_inv;
                    end
                end
                for (int i = 1; i < STAGES; i++) begin
                    if (ld[i]) begin
                        vld[i] <= vld[i-1];
                        if (vld[i-1]) begin
                            dat[i]   <= dat[i-1];
                            inv_q[i] <= inv_q[i-1];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb_aes_sbox_pipe: randomized and directed checks of aes_sbox_pipe against
// a table model built from GF(2^8) arithmetic and a beat scoreboard.
module tb_aes_sbox_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;
    localparam int DW     = 8 * LANES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_inv;
    logic [CNT_W-1:0]  beat_cnt;
    logic              busy;

    always #5 clk = ~clk;

    aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inv(out_inv),
        .beat_cnt(beat_cnt), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] fwd [256];
    logic [7:0] rev [256];

    function automatic int gmul(input int a, input int b);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11b;
        end
        return r;
    endfunction

    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            int iv = 0;
            int s  = 0;
            for (int b = 1; b < 256; b++) begin
                if (gmul(a, b) == 1) iv = b;
            end
            for (int i = 0; i < 8; i++) begin
                int bv;
                bv = ((iv >> i) ^ (iv >> ((i + 4) % 8)) ^ (iv >> ((i + 5) % 8))
                     ^ (iv >> ((i + 6) % 8)) ^ (iv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
                s = s | (bv << i);
            end
            fwd[a] = 8'(s);
            rev[s] = 8'(a);
        end
    endtask

    function automatic logic [DW-1:0] ref_sub(input logic inv, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[8*l +: 8] = inv ? rev[d[8*l +: 8]] : fwd[d[8*l +: 8]];
        end
        return r;
    endfunction

    logic [DW:0]   exp_q [$];
    logic [DW-1:0] out_log [$];
    int            exp_cnt = 0;
    bit            mon_on  = 1'b0;
    bit            stall   = 1'b0;
    logic [DW:0]   held;

    always @(negedge clk) begin
        if (mon_on) begin
            check("beat_cnt", beat_cnt, exp_cnt);
            if (stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_beat", {out_inv, out_data}, held);
            end
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt = 0;
                stall   = 1'b0;
            end else if (flush) begin
                exp_q.delete();
                stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_log.push_back(out_data);
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("beat", {out_inv, out_data}, exp_q.pop_front());
                    exp_cnt = (exp_cnt + 1) % 65536;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({in_inv, ref_sub(in_inv, in_data)});
                end
                stall = out_valid && !out_ready;
                held  = {out_inv, out_data};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic inv, input logic [DW-1:0] d, output int lat);
        in_valid  = 1'b1;
        in_inv    = inv;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        check("send_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        check(tag, idle, 1'b1);
    endtask

    logic [DW-1:0] orig [256];
    logic [DW-1:0] fwd_out [$];
    logic [DW-1:0] d;
    int lat, sent, acc, cnt0, n;

    initial begin
        build_tables();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
        in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_inv", out_inv, 1'b0);
        check("rst_beat_cnt", beat_cnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        mon_on = 1'b1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        tick();

        send_one(1'b0, 32'h5301FF00, lat);
        check("fwd_latency", lat, STAGES);
        check("fwd_data", out_data, 32'hED7C1663);
        check("fwd_inv", out_inv, 1'b0);
        tick();
        send_one(1'b1, 32'h537C1663, lat);
        check("inv_latency", lat, STAGES);
        check("inv_data", out_data, 32'h5001FF00);
        check("inv_inv", out_inv, 1'b1);
        tick();

        for (int i = 0; i < 256; i++) orig[i] = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            out_log.delete();
            out_ready = 1'b1;
            sent = 0;
            for (int k = 0; k < 1000 && sent < 256; k++) begin
                in_valid = 1'b1;
                in_inv   = (pass == 1);
                in_data  = (pass == 0) ? orig[sent] : fwd_out[sent];
                #1;
                if (in_ready) sent++;
                tick();
            end
            in_valid = 1'b0;
            for (int k = 0; k < 50 && out_log.size() < 256; k++) tick();
            check("rt_count", out_log.size(), 256);
            if (pass == 0) fwd_out = out_log;
        end
        for (int i = 0; i < 256 && i < out_log.size(); i++) begin
            check("round_trip", out_log[i], orig[i]);
        end

        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_inv   = 1'($urandom);
            in_data  = $urandom;
            #1;
            if (in_ready) acc++;
            tick();
        end
        #1;
        check("stall_accepts", acc, STAGES);
        check("full_in_ready", in_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        check("full_out_valid", out_valid, 1'b1);
        cnt0 = exp_cnt;
        out_ready = 1'b1;
        #1;
        check("shift_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_idle("drain3_idle");
        check("drain3_cnt", beat_cnt, (cnt0 + 3) % 65536);

        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_inv    = 1'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("rand_idle");
        check("rand_queue_empty", exp_q.size(), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        tick();
        in_data   = $urandom;
        tick();
        #1;
        check("preflush_busy", busy, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        cnt0 = exp_cnt;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_busy", busy, 1'b0);
        check("flush_cnt", beat_cnt, cnt0);
        d = $urandom;
        send_one(1'b0, d, lat);
        check("postflush_latency", lat, STAGES);
        check("postflush_data", out_data, ref_sub(1'b0, d));
        tick();

        n = 65535 - exp_cnt;
        out_ready = 1'b1;
        sent = 0;
        for (int k = 0; k < n + 100 && sent < n; k++) begin
            in_valid = 1'b1;
            in_inv   = 1'($urandom);
            in_data  = $urandom;
            #1;
            if (in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        wait_idle("preload_idle");
        check("cnt_max", beat_cnt, 16'hFFFF);
        d = $urandom;
        send_one(1'b1, d, lat);
        check("wrap_data", out_data, ref_sub(1'b1, d));
        tick();
        #1;
        check("cnt_wrap", beat_cnt, 16'h0000);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        tick();
        in_data   = $urandom;
        tick();
        #1;
        check("prerst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, '0);
        check("mrst_out_inv", out_inv, 1'b0);
        check("mrst_beat_cnt", beat_cnt, '0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mrel_in_ready", in_ready, 1'b1);
        tick();
        tick();
        #1;
        check("mrel_no_ghost", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
